// File: rtl/text_console_pkg.sv
// rtl/text_console_pkg.sv - shared constants for the text console writer
package text_console_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  typedef logic [1:0] state_t;
  localparam state_t ST_CLEAR = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;

  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_SPACE = 8'h20;

endpackage

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte stream to character/attribute RAM writer
// Interprets CR/LF/BS/FF, wraps the cursor without scrolling, clears the screen on reset and FF.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int         COLS         = DEF_COLS,
  parameter int         ROWS         = DEF_ROWS,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CHAR_VALID,
  input  logic [7:0]  CHAR_DATA,
  output logic        CHAR_READY,
  input  logic        ATTR_WE,
  input  logic [7:0]  ATTR_DATA,
  output logic [12:0] RAM_ADDRESS,
  output logic [7:0]  RAM_CHAR_WDATA,
  output logic [7:0]  RAM_ATTR_WDATA,
  output logic        RAM_WE,
  output logic [6:0]  CURSOR_COL,
  output logic [5:0]  CURSOR_ROW,
  output logic        BUSY
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d, clr_col_q, clr_col_d;
  logic [5:0]  row_q, row_d, clr_row_q, clr_row_d;
  logic [7:0]  attr_q, attr_d, clr_attr_q, clr_attr_d;
  logic        clr_last_q, clr_last_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  wchar_q, wchar_d, wattr_q, wattr_d;
  logic        we_q, we_d, ready_q, ready_d, busy_q, busy_d;
  logic        accept, clr_issue;
  logic [7:0]  clr_wattr;

  assign accept = CHAR_VALID && (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    clr_col_d  = clr_col_q;
    clr_row_d  = clr_row_q;
    clr_attr_d = clr_attr_q;
    clr_last_d = clr_last_q;
    attr_d     = ATTR_WE ? ATTR_DATA : attr_q;
    addr_d     = addr_q;
    wchar_d    = wchar_q;
    wattr_d    = wattr_q;
    we_d       = 1'b0;
    clr_issue  = 1'b0;
    clr_wattr  = clr_attr_q;

    case (state_q)
      ST_CLEAR: begin
        if (clr_last_q) begin
          state_d    = ST_IDLE;
          clr_last_d = 1'b0;
          clr_col_d  = '0;
          clr_row_d  = '0;
          col_d      = '0;
          row_d      = '0;
        end else begin
          clr_issue = 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (CHAR_DATA >= CC_SPACE) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
            addr_d  = {row_q, col_q};
            wchar_d = CHAR_DATA;
            wattr_d = attr_q;
          end else if (CHAR_DATA == CC_CR) begin
            col_d = '0;
          end else if (CHAR_DATA == CC_LF) begin
            row_d = (row_q == LAST_ROW) ? '0 : row_q + 6'd1;
          end else if (CHAR_DATA == CC_BS) begin
            if (col_q != '0) begin
              col_d = col_q - 7'd1;
            end else if (row_q != '0) begin
              col_d = LAST_COL;
              row_d = row_q - 6'd1;
            end
          end else if (CHAR_DATA == CC_FF) begin
            // First cell is issued on the accepting edge so the clear spans COLS*ROWS busy cycles.
            state_d    = ST_CLEAR;
            clr_attr_d = attr_q;
            clr_issue  = 1'b1;
            clr_wattr  = attr_q;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = (row_q == LAST_ROW) ? '0 : row_q + 6'd1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    if (clr_issue) begin
      we_d    = 1'b1;
      addr_d  = {clr_row_q, clr_col_q};
      wchar_d = CC_SPACE;
      wattr_d = clr_wattr;
      if (clr_col_q == LAST_COL) begin
        clr_col_d = '0;
        if (clr_row_q == LAST_ROW) clr_last_d = 1'b1;
        else                       clr_row_d  = clr_row_q + 6'd1;
      end else begin
        clr_col_d = clr_col_q + 7'd1;
      end
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_CLEAR);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_CLEAR;
      col_q      <= '0;
      row_q      <= '0;
      clr_col_q  <= '0;
      clr_row_q  <= '0;
      clr_attr_q <= DEFAULT_ATTR;
      clr_last_q <= 1'b0;
      attr_q     <= DEFAULT_ATTR;
      addr_q     <= '0;
      wchar_q    <= '0;
      wattr_q    <= '0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      clr_col_q  <= clr_col_d;
      clr_row_q  <= clr_row_d;
      clr_attr_q <= clr_attr_d;
      clr_last_q <= clr_last_d;
      attr_q     <= attr_d;
      addr_q     <= addr_d;
      wchar_q    <= wchar_d;
      wattr_q    <= wattr_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign CHAR_READY     = ready_q;
  assign BUSY           = busy_q;
  assign RAM_WE         = we_q;
  assign RAM_ADDRESS    = addr_q;
  assign RAM_CHAR_WDATA = wchar_q;
  assign RAM_ATTR_WDATA = wattr_q;
  assign CURSOR_COL     = col_q;
  assign CURSOR_ROW     = row_q;

endmodule
